// File: rtl/golden_nonce_queue_if.sv
// Bundles the hashing-core push side, the serial transmitter handshake and
// the queue status into one interface.
interface golden_nonce_queue_if #(
    parameter int unsigned ADDR_W = 3
);
    localparam int unsigned WORD_W = 32;

    logic [WORD_W-1:0] golden_nonce;
    logic              golden_valid;
    logic              tx_busy;
    logic              send;
    logic [WORD_W-1:0] word;
    logic [ADDR_W:0]   count;
    logic              overflow;

    // Environment side: hashing core plus transmitter.
    modport master (
        output golden_nonce, golden_valid, tx_busy,
        input  send, word, count, overflow
    );

    // Queue side.
    modport slave (
        input  golden_nonce, golden_valid, tx_busy,
        output send, word, count, overflow
    );
endinterface

// File: rtl/golden_nonce_queue.sv
// Golden nonce queue: buffers nonces from the hashing core in a circular
// buffer and launches them one word at a time into the serial transmitter.
module golden_nonce_queue #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    golden_nonce_queue_if.slave  bus
);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned TMO_W  = 2;

    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(3);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_BUSY = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              send_q, send_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              launch;
    logic              push_ok;

    logic [WORD_W-1:0] mem [DEPTH];

    // Next-state, launch/pop, push/overflow and occupancy decisions.
    always_comb begin
        state_d    = state_q;
        send_d     = 1'b0;
        word_d     = word_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tmo_d      = tmo_q;
        launch     = 1'b0;
        push_ok    = 1'b0;

        case (state_q)
            IDLE: begin
                // tx_busy=0 also stops a launch into a stale byte train after reset
                if ((count_q != '0) && !bus.tx_busy) begin
                    launch   = 1'b1;
                    send_d   = 1'b1;
                    word_d   = mem[rd_ptr_q];
                    rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                    tmo_d    = '0;
                    state_d  = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // A transmitter that never goes busy must not stall the queue
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A pop in the same cycle frees the slot, so a full queue still accepts
        if (bus.golden_valid) begin
            if ((count_q != FULL) || launch) begin
                push_ok  = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end

        case ({push_ok, launch})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and output registers; reset drops send immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            send_q     <= 1'b0;
            word_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            send_q     <= send_d;
            word_q     <= word_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tmo_q      <= tmo_d;
        end
    end

    // Queue storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= bus.golden_nonce;
        end
    end

    assign bus.send     = send_q;
    assign bus.word     = word_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule
